// File: rtl/csa_seq_add_ctrl.sv
// rtl/csa_seq_add_ctrl.sv - wide adder built by time-sharing one registered SLICE-bit add slice
//
// Optional build macro: CSA_SEQ_ADD_SUB_EN adds a 'sub' input that selects a-b
// (b inverted, carry seeded with 1) on the accept edge.
//
// Flow: IDLE accepts a/b/cin, RUN adds one slice per clock LSB first with the
// carry fed back through a register, DONE presents sum/cout until out_ready.
module csa_seq_add_ctrl #(
  parameter int SLICE  = 7,
  parameter int NSLICE = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLICE*NSLICE-1:0] a,
  input  logic [SLICE*NSLICE-1:0] b,
  input  logic                    cin,
`ifdef CSA_SEQ_ADD_SUB_EN
  input  logic                    sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SLICE*NSLICE-1:0] sum,
  output logic                    cout
);

  localparam int W  = SLICE * NSLICE;
  localparam int CW = $clog2(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            cout_q;
  logic [W-1:0]    a_sr;
  logic [W-1:0]    b_sr;
  logic [W-1:0]    sum_sr;
  logic [SLICE:0]  r;
  logic            last_slice;
  logic            accept;
  logic [W-1:0]    b_load;
  logic            carry_load;

  // Operand conditioning applied at the accept edge (subtract = add inverted b plus one)
`ifdef CSA_SEQ_ADD_SUB_EN
  always_comb begin
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load     = b;
    carry_load = cin;
  end
`endif

  // The single shared slice adder: low slice of each operand plus the fed-back carry
  always_comb begin
    r          = {1'b0, a_sr[SLICE-1:0]} + {1'b0, b_sr[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};
    last_slice = (cnt_q == CW'(NSLICE - 1));
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; in_ready is held low while reset is asserted
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~reset;
        accept   = in_valid & ~reset;
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, then shift one slice per RUN cycle; sum/cout hold otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sr    <= a;
            b_sr    <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_sr  <= {r[SLICE-1:0], sum_sr[W-1:SLICE]};
          carry_q <= r[SLICE];
          a_sr    <= a_sr >> SLICE;
          b_sr    <= b_sr >> SLICE;
          cnt_q   <= last_slice ? '0 : cnt_q + CW'(1);
          if (last_slice) begin
            cout_q <= r[SLICE];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_sr;
  assign cout = cout_q;

endmodule
